accel_spi3_responder: RTL

- Synthesizable 3-wire SPI responder emulating the accelerometer end of the accelerometer SPI conduit (I2C_SCLK, G_SENSOR_CS_N, I2C_SDAT, G_SENSOR_INT).
- Used as an in-FPGA stand-in sensor for board bring-up and for closed-loop regression of the SoC's SPI master.
- Oversamples SCLK/CS_N/SDAT in the clk_clk domain and decodes command, read and write bytes.
- Serves a 64x8 register map; a local port loads X/Y/Z samples and raises the interrupt.

---
 rtl/accel_spi3_responder.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/accel_spi3_responder.sv
// accel_spi3_responder: 3-wire SPI (mode 3) responder that emulates the
// accelerometer end of the sensor conduit. SCLK/CS_N/SDAT are oversampled in
// the clk_clk domain. The responder serves a 64x8 register map, and a local
// port loads X/Y/Z samples and raises DATA_READY.
// Optional build macro: ACCEL_SPI_RESP_TIMEOUT_EN. When it is defined, a
// transaction with CS low and SCLK stalled for TIMEOUT_CYCLES is aborted.
// Handshake: sample_valid is a one-cycle strobe with no back-pressure. A
// strobe is always accepted. With CS high the sample is applied directly.
// With CS low it is parked in a shadow buffer until the synchronized CS rise.
module accel_spi3_responder #(
  parameter logic [7:0] DEVID          = 8'hE5,
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_sdat_i,
  output logic        spi_sdat_o,
  output logic        spi_sdat_oe,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  output logic        int_o,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdat_sync;
  logic                   sclk_q, cs_q;
  logic                   sclk_s, cs_s, sdat_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [2:0]             bit_cnt;
  logic [7:0]             sh;
  logic [5:0]             addr;
  logic                   mb;
  logic [7:0]             regs [0:63];
  logic [47:0]            data_q, shadow_q;
  logic                   shadow_pend, dready;
  logic                   timeout;
  logic                   load_en;
  logic [5:0]             load_addr, next_addr;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sdat_s    = sdat_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign busy      = ~cs_s;
  assign dbg_state = state;

  function automatic logic is_data(input logic [5:0] a);
    return (a >= 6'h32) && (a <= 6'h37);
  endfunction

  function automatic logic is_ro(input logic [5:0] a);
    return (a == 6'h00) || (a == 6'h30) || is_data(a);
  endfunction

  // Value presented by a register read; RO entries are synthesized here.
  function automatic logic [7:0] rd_val(input logic [5:0] a);
    case (a)
      6'h00:   return DEVID;
      6'h30:   return {dready, 7'b0};
      6'h32:   return data_q[7:0];
      6'h33:   return data_q[15:8];
      6'h34:   return data_q[23:16];
      6'h35:   return data_q[31:24];
      6'h36:   return data_q[39:32];
      6'h37:   return data_q[47:40];
      default: return regs[a];
    endcase
  endfunction

  // Synchronize the pad inputs and keep the previous value for edge detection.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      sdat_sync <= '1;
      sclk_q    <= 1'b1;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], spi_sdat_i};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

`ifdef ACCEL_SPI_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Count clk_clk cycles with CS low and no SCLK edge; saturate at the limit.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      to_cnt <= '0;
    end else if (cs_s || sclk_rise || sclk_fall) begin
      to_cnt <= '0;
    end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  // Decide whether this cycle loads a read byte, and from which address.
  always_comb begin
    load_en   = 1'b0;
    load_addr = addr;
    next_addr = mb ? addr + 6'd1 : addr;
    if (!(cs_rise || timeout) && sclk_rise && bit_cnt == 3'd7) begin
      if (state == S_CMD) begin
        load_addr = {sh[4:0], sdat_s};
        load_en   = sh[6];
      end else if (state == S_RD) begin
        load_addr = next_addr;
        load_en   = 1'b1;
      end
    end
  end

  // Transaction FSM, register file, sample/shadow handling and DATA_READY.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state       <= S_IDLE;
      bit_cnt     <= 3'd0;
      sh          <= 8'h00;
      addr        <= 6'h00;
      mb          <= 1'b0;
      spi_sdat_o  <= 1'b1;
      spi_sdat_oe <= 1'b0;
      data_q      <= '0;
      shadow_q    <= '0;
      shadow_pend <= 1'b0;
      dready      <= 1'b0;
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
    end else begin
      if (cs_rise || timeout) begin
        state       <= S_IDLE;
        bit_cnt     <= 3'd0;
        spi_sdat_o  <= 1'b1;
        spi_sdat_oe <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              state   <= S_CMD;
              bit_cnt <= 3'd0;
            end
          end
          S_CMD: begin
            if (sclk_rise) begin
              sh      <= {sh[6:0], sdat_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= load_addr;
                mb   <= sh[5];
                if (sh[6]) begin
                  state <= S_RD;
                  sh    <= rd_val(load_addr);
                end else begin
                  state <= S_WR;
                end
              end
            end
          end
          S_RD: begin
            if (sclk_fall) begin
              spi_sdat_o  <= sh[7];
              spi_sdat_oe <= 1'b1;
              sh          <= {sh[6:0], 1'b0};
            end else if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= load_addr;
                sh   <= rd_val(load_addr);
              end
            end
          end
          S_WR: begin
            if (sclk_rise) begin
              sh      <= {sh[6:0], sdat_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (!is_ro(addr)) regs[addr] <= {sh[6:0], sdat_s};
                addr <= next_addr;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end

      // A direct sample wins over a pending shadow applied on the same cycle.
      if (sample_valid && cs_s) begin
        data_q <= {sample_z, sample_y, sample_x};
      end else if (cs_rise && shadow_pend) begin
        data_q <= shadow_q;
      end

      if (sample_valid && !cs_s) begin
        shadow_q    <= {sample_z, sample_y, sample_x};
        shadow_pend <= 1'b1;
      end else if (cs_rise) begin
        shadow_pend <= 1'b0;
      end

      if ((sample_valid && cs_s) || (cs_rise && shadow_pend)) begin
        dready <= 1'b1;
      end else if (load_en && is_data(load_addr)) begin
        dready <= 1'b0;
      end
    end
  end

  // Interrupt output: DATA_READY gated by INT_ENABLE bit 7.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) int_o <= 1'b0;
    else             int_o <= dready & regs[6'h2E][7];
  end

endmodule
